// File: rtl/demux_buffered.sv
// ---- demux_buffered: 1-to-2 demultiplexer with a DEPTH-entry FIFO per output ----
// ---- rev 1.0 ----
`default_nettype none

module demux_buffered #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           din,
  input  logic                       s,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           y0,
  output logic                       y0_valid,
  input  logic                       y0_ready,
  output logic [WIDTH-1:0]           y1,
  output logic                       y1_valid,
  input  logic                       y1_ready,
  output logic [$clog2(DEPTH+1)-1:0] cnt0,
  output logic [$clog2(DEPTH+1)-1:0] cnt1
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [1:0]       full;
  logic [1:0]       nonempty;
  logic [1:0]       out_ready;
  logic [WIDTH-1:0] head [2];
  logic [CW-1:0]    count [2];

  assign out_ready = {y1_ready, y0_ready};

  // Acceptance looks only at the selected queue's occupancy, never at the consumer side.
  assign in_ready = s ? !full[1] : !full[0];

  generate
    for (genvar n = 0; n < 2; n++) begin : g_queue
      logic [WIDTH-1:0] mem [DEPTH];
      logic [PW-1:0]    wr_ptr;
      logic [PW-1:0]    rd_ptr;
      logic [CW-1:0]    occ;
      logic             sel;
      logic             push;
      logic             pop;

      assign sel         = (n == 0) ? !s : s;
      assign push        = in_valid && in_ready && sel;
      assign pop         = nonempty[n] && out_ready[n];
      assign nonempty[n] = (occ != '0);
      assign full[n]     = (occ == CW'(DEPTH));
      assign head[n]     = mem[rd_ptr];
      assign count[n]    = occ;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
          end
          wr_ptr <= '0;
          rd_ptr <= '0;
          occ    <= '0;
        end else begin
          if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
          end
          // Explicit wrap keeps non-power-of-two depths correct.
          if (pop) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
          end
          case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
          endcase
        end
      end
    end
  endgenerate

  assign y0       = head[0];
  assign y1       = head[1];
  assign y0_valid = nonempty[0];
  assign y1_valid = nonempty[1];
  assign cnt0     = count[0];
  assign cnt1     = count[1];

endmodule

`default_nettype wire
